// File: rtl/ext_ram_fifo_pkg.sv
// Shared constants, types and helpers for the external-RAM multi-channel FIFO controller.
package ext_ram_fifo_pkg;

  localparam int cRD_LAT_MAX = 4;
  localparam int cCW_MAX     = 4;

  typedef struct packed {
    logic               vld;
    logic [cCW_MAX-1:0] ch;
  } t_rd_tag;

  // Channel index width; a single channel still needs a 1-bit index port.
  function automatic int fn_clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ext_ram_fifo_rd_pipe.sv
// Read-return path: delays the valid/channel tag by the RAM read latency and
// registers the returned RAM word together with its tag.
module ext_ram_fifo_rd_pipe
  import ext_ram_fifo_pkg::*;
#(
  parameter int pW      = 36,
  parameter int pCW     = 2,
  parameter int pRD_LAT = 2
) (
  input  logic           iclk,
  input  logic           irst,
  input  logic           iclk_ena,
  input  t_rd_tag        itag,
  input  logic [pW-1:0]  iram_dat,
  output logic           oval,
  output logic [pCW-1:0] och,
  output logic [pW-1:0]  ordat
);

  localparam int cLAT = (pRD_LAT < 1) ? 1 :
                        (pRD_LAT > cRD_LAT_MAX) ? cRD_LAT_MAX : pRD_LAT;

  t_rd_tag        tag_q [cLAT];
  t_rd_tag        tag_d [cLAT];
  logic           oval_q, oval_d;
  logic [pCW-1:0] och_q, och_d;
  logic [pW-1:0]  ordat_q, ordat_d;
  logic           unused_ok;

  always_comb begin
    tag_d[0] = itag;
    for (int i = 1; i < cLAT; i++) tag_d[i] = tag_q[i-1];
    oval_d  = tag_q[cLAT-1].vld;
    och_d   = tag_q[cLAT-1].ch[pCW-1:0];
    ordat_d = tag_q[cLAT-1].vld ? iram_dat : ordat_q;
  end

  assign unused_ok = &{1'b0, tag_q[cLAT-1].ch};

  // Tag line stage cLAT-1 lines up with iram_dat; output register follows.
  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int i = 0; i < cLAT; i++) tag_q[i] <= '0;
      oval_q  <= 1'b0;
      och_q   <= '0;
      ordat_q <= '0;
    end else if (iclk_ena) begin
      for (int i = 0; i < cLAT; i++) tag_q[i] <= tag_d[i];
      oval_q  <= oval_d;
      och_q   <= och_d;
      ordat_q <= ordat_d;
    end
  end

  assign oval  = oval_q;
  assign och   = och_q;
  assign ordat = ordat_q;

endmodule

// File: rtl/ext_ram_fifo_ctrl.sv
// Multi-channel ring-buffer FIFO controller for an external simple-dual-port RAM.
// Optional fill-count output ousedw is enabled by defining EXT_RAM_FIFO_USEDW_EN.
module ext_ram_fifo_ctrl
  import ext_ram_fifo_pkg::*;
#(
  parameter  int pW      = 36,
  parameter  int pA      = 18,
  parameter  int pCH     = 4,
  parameter  int pRD_LAT = 2,
  localparam int pCW     = fn_clog2_min1(pCH),
  localparam int pDA     = pA - pCW
) (
  input  logic           iclk,
  input  logic           irst,
  input  logic           iclk_ena,
  input  logic           iena,
  input  logic [pCW-1:0] ich,
  input  logic [pW-1:0]  idat,
  input  logic           irdreq,
  input  logic [pCW-1:0] irdch,
  input  logic           iclr_flags,
  output logic           owrena,
  output logic [pA-1:0]  owr_adr,
  output logic [pW-1:0]  odat,
  output logic           ordena,
  output logic [pA-1:0]  ord_adr,
  input  logic [pW-1:0]  iram_dat,
  output logic           oval,
  output logic [pCW-1:0] och,
  output logic [pW-1:0]  ordat,
  output logic [pCH-1:0] ofull,
  output logic [pCH-1:0] oempty,
  output logic [pCH-1:0] oovf,
  output logic [pCH-1:0] oudf
`ifdef EXT_RAM_FIFO_USEDW_EN
 ,output logic [pCH*(pDA+1)-1:0] ousedw
`endif
);

  localparam int pPW = pDA + 1;

  logic [pPW-1:0] wr_ptr_q [pCH];
  logic [pPW-1:0] wr_ptr_d [pCH];
  logic [pPW-1:0] rd_ptr_q [pCH];
  logic [pPW-1:0] rd_ptr_d [pCH];
  logic           owrena_q, owrena_d;
  logic [pA-1:0]  owr_adr_q, owr_adr_d;
  logic [pW-1:0]  odat_q, odat_d;
  logic           ordena_q, ordena_d;
  logic [pA-1:0]  ord_adr_q, ord_adr_d;
  logic [pCH-1:0] full_q, full_d;
  logic [pCH-1:0] empty_q, empty_d;
  logic [pCH-1:0] ovf_q, ovf_d;
  logic [pCH-1:0] udf_q, udf_d;
  logic           wr_ok, rd_ok;
  logic [pDA-1:0] wr_lo, rd_lo;
  t_rd_tag        rd_tag;

  // Both requests are judged against the flags registered last cycle, so a
  // same-cycle read never makes room for a write and vice versa.
  always_comb begin
    wr_ok   = 1'b0;
    rd_ok   = 1'b0;
    wr_lo   = '0;
    rd_lo   = '0;
    full_d  = full_q;
    empty_d = empty_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    for (int c = 0; c < pCH; c++) begin
      logic wsel, rsel;
      wsel        = iena && (int'(ich) == c);
      rsel        = irdreq && (int'(irdch) == c);
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      if (wsel) wr_lo = wr_ptr_q[c][pDA-1:0];
      if (rsel) rd_lo = rd_ptr_q[c][pDA-1:0];
      if (wsel && !full_q[c]) begin
        wr_ok       = 1'b1;
        wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
      end
      if (rsel && !empty_q[c]) begin
        rd_ok       = 1'b1;
        rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
      end
      ovf_d[c]   = (ovf_q[c] & ~iclr_flags) | (wsel & full_q[c]);
      udf_d[c]   = (udf_q[c] & ~iclr_flags) | (rsel & empty_q[c]);
      empty_d[c] = (wr_ptr_d[c] == rd_ptr_d[c]);
      full_d[c]  = (wr_ptr_d[c][pDA-1:0] == rd_ptr_d[c][pDA-1:0]) &&
                   (wr_ptr_d[c][pDA] != rd_ptr_d[c][pDA]);
    end
    owrena_d  = wr_ok;
    owr_adr_d = wr_ok ? {ich, wr_lo} : owr_adr_q;
    odat_d    = wr_ok ? idat : odat_q;
    ordena_d  = rd_ok;
    ord_adr_d = rd_ok ? {irdch, rd_lo} : ord_adr_q;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int c = 0; c < pCH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      owrena_q  <= 1'b0;
      owr_adr_q <= '0;
      odat_q    <= '0;
      ordena_q  <= 1'b0;
      ord_adr_q <= '0;
      full_q    <= '0;
      empty_q   <= '1;
      ovf_q     <= '0;
      udf_q     <= '0;
    end else if (iclk_ena) begin
      for (int c = 0; c < pCH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
      end
      owrena_q  <= owrena_d;
      owr_adr_q <= owr_adr_d;
      odat_q    <= odat_d;
      ordena_q  <= ordena_d;
      ord_adr_q <= ord_adr_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

`ifdef EXT_RAM_FIFO_USEDW_EN
  logic [pCH*pPW-1:0] usedw_q, usedw_d;

  always_comb begin
    usedw_d = '0;
    for (int c = 0; c < pCH; c++) usedw_d[c*pPW +: pPW] = wr_ptr_d[c] - rd_ptr_d[c];
  end

  always_ff @(posedge iclk) begin
    if (irst)          usedw_q <= '0;
    else if (iclk_ena) usedw_q <= usedw_d;
  end

  assign ousedw = usedw_q;
`endif

  // The channel of a read travels with it as part of the address.
  always_comb begin
    rd_tag     = '0;
    rd_tag.vld = ordena_q;
    rd_tag.ch  = cCW_MAX'(ord_adr_q[pA-1 -: pCW]);
  end

  ext_ram_fifo_rd_pipe #(
    .pW      (pW),
    .pCW     (pCW),
    .pRD_LAT (pRD_LAT)
  ) u_rd_pipe (
    .iclk     (iclk),
    .irst     (irst),
    .iclk_ena (iclk_ena),
    .itag     (rd_tag),
    .iram_dat (iram_dat),
    .oval     (oval),
    .och      (och),
    .ordat    (ordat)
  );

  assign owrena  = owrena_q;
  assign owr_adr = owr_adr_q;
  assign odat    = odat_q;
  assign ordena  = ordena_q;
  assign ord_adr = ord_adr_q;
  assign ofull   = full_q;
  assign oempty  = empty_q;
  assign oovf    = ovf_q;
  assign oudf    = udf_q;

endmodule

// File: tb/tb_ext_ram_fifo_ctrl.sv
// Directed bench for ext_ram_fifo_ctrl with a behavioural RAM, a per-channel
// FIFO model and a read-return scoreboard.
module tb_ext_ram_fifo_ctrl;

  localparam int W   = 8;
  localparam int A   = 6;
  localparam int CH  = 4;
  localparam int LAT = 2;
  localparam int DEP = 16;

  logic         iclk = 1'b0;
  logic         irst = 1'b1;
  logic         iclk_ena = 1'b1;
  logic         iena = 1'b0;
  logic [1:0]   ich = '0;
  logic [W-1:0] idat = '0;
  logic         irdreq = 1'b0;
  logic [1:0]   irdch = '0;
  logic         iclr_flags = 1'b0;
  logic         owrena, ordena, oval;
  logic [A-1:0] owr_adr, ord_adr;
  logic [W-1:0] odat, ordat;
  logic [W-1:0] iram_dat = '0;
  logic [1:0]   och;
  logic [CH-1:0] ofull, oempty, oovf, oudf;
`ifdef EXT_RAM_FIFO_USEDW_EN
  logic [CH*5-1:0] ousedw;
`endif

  ext_ram_fifo_ctrl #(.pW(W), .pA(A), .pCH(CH), .pRD_LAT(LAT)) dut (
    .iclk(iclk), .irst(irst), .iclk_ena(iclk_ena),
    .iena(iena), .ich(ich), .idat(idat),
    .irdreq(irdreq), .irdch(irdch), .iclr_flags(iclr_flags),
    .owrena(owrena), .owr_adr(owr_adr), .odat(odat),
    .ordena(ordena), .ord_adr(ord_adr), .iram_dat(iram_dat),
    .oval(oval), .och(och), .ordat(ordat),
`ifdef EXT_RAM_FIFO_USEDW_EN
    .ousedw(ousedw),
`endif
    .ofull(ofull), .oempty(oempty), .oovf(oovf), .oudf(oudf)
  );

  always #5 iclk = ~iclk;

  // Behavioural RAM: two enabled cycles of read latency.
  logic [W-1:0] mem [64];
  logic [W-1:0] rd_s1 = '0;
  always @(posedge iclk) begin
    if (iclk_ena) begin
      if (owrena) mem[owr_adr] <= odat;
      if (ordena) rd_s1 <= mem[ord_adr];
      iram_dat <= rd_s1;
    end
  end

  int   ecnt = 0;
  logic en_seen = 1'b0;
  always @(posedge iclk) begin
    en_seen <= iclk_ena && !irst;
    if (iclk_ena && !irst) ecnt <= ecnt + 1;
  end

  typedef struct {
    logic [1:0]   ch;
    logic [W-1:0] d;
    int           t;
  } rd_exp_t;

  rd_exp_t      sb[$];
  logic [W-1:0] mq [CH][$];
  int           wp [CH];
  int           rp [CH];
  logic [CH-1:0] m_ovf, m_udf;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      wp[c] = 0;
      rp[c] = 0;
      mq[c].delete();
    end
    m_ovf = '0;
    m_udf = '0;
    sb.delete();
  endtask

  task automatic check_flags(input string tag);
    logic [CH-1:0] e_emp, e_full;
    for (int c = 0; c < CH; c++) begin
      e_emp[c]  = (wp[c] == rp[c]);
      e_full[c] = ((wp[c] - rp[c]) == DEP);
    end
    chk({tag, "/oempty"}, 32'(oempty), 32'(e_emp));
    chk({tag, "/ofull"},  32'(ofull),  32'(e_full));
    chk({tag, "/oovf"},   32'(oovf),   32'(m_ovf));
    chk({tag, "/oudf"},   32'(oudf),   32'(m_udf));
`ifdef EXT_RAM_FIFO_USEDW_EN
    for (int c = 0; c < CH; c++) chk({tag, "/ousedw"}, 32'(ousedw[c*5 +: 5]), 32'(wp[c] - rp[c]));
`endif
  endtask

  task automatic step(input string tag, input logic we, input logic [1:0] wc, input logic [W-1:0] wd,
                      input logic re, input logic [1:0] rc, input logic clr);
    logic en, ew, er;
    logic [A-1:0] wa, ra;
    logic [CH-1:0] sov, sud;
    rd_exp_t e;
    int t0;
    en  = iclk_ena && !irst;
    ew  = we && ((wp[wc] - rp[wc]) < DEP);
    er  = re && ((wp[rc] - rp[rc]) > 0);
    wa  = {wc, 4'(wp[wc] % DEP)};
    ra  = {rc, 4'(rp[rc] % DEP)};
    sov = (we && !ew) ? 4'(1 << wc) : 4'h0;
    sud = (re && !er) ? 4'(1 << rc) : 4'h0;
    t0  = ecnt;
    iena = we; ich = wc; idat = wd; irdreq = re; irdch = rc; iclr_flags = clr;
    @(posedge iclk); #1;
    iena = 1'b0; irdreq = 1'b0; iclr_flags = 1'b0;
    if (en) begin
      chk({tag, "/owrena"}, 32'(owrena), 32'(ew));
      if (ew) begin
        chk({tag, "/owr_adr"}, 32'(owr_adr), 32'(wa));
        chk({tag, "/odat"}, 32'(odat), 32'(wd));
        mq[wc].push_back(wd);
        wp[wc]++;
      end
      chk({tag, "/ordena"}, 32'(ordena), 32'(er));
      if (er) begin
        chk({tag, "/ord_adr"}, 32'(ord_adr), 32'(ra));
        e.ch = rc;
        e.d  = mq[rc].pop_front();
        e.t  = t0 + LAT + 2;
        sb.push_back(e);
        rp[rc]++;
      end
      m_ovf = (clr ? 4'h0 : m_ovf) | sov;
      m_udf = (clr ? 4'h0 : m_udf) | sud;
    end
    check_flags(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic monitor();
    rd_exp_t e;
    forever begin
      @(negedge iclk);
      if (en_seen && oval) begin
        tests++;
        assert (sb.size() > 0) else begin
          fails++;
          $error("FAIL oval_unexpected: observed oval=1 ch=%0d dat=%0h expected no pending read", och, ordat);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rd/och", 32'(och), 32'(e.ch));
          chk("rd/ordat", 32'(ordat), 32'(e.d));
          chk("rd/latency_cycle", 32'(ecnt), 32'(e.t));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge iclk);
    #1;
    chk("rst/oempty", 32'(oempty), 32'hF);
    chk("rst/ofull", 32'(ofull), 32'h0);
    chk("rst/oovf", 32'(oovf), 32'h0);
    chk("rst/oudf", 32'(oudf), 32'h0);
    chk("rst/owrena", 32'(owrena), 32'h0);
    chk("rst/ordena", 32'(ordena), 32'h0);
    chk("rst/oval", 32'(oval), 32'h0);
    chk("rst/owr_adr", 32'(owr_adr), 32'h0);
    chk("rst/ord_adr", 32'(ord_adr), 32'h0);
    chk("rst/odat", 32'(odat), 32'h0);
    chk("rst/ordat", 32'(ordat), 32'h0);
    chk("rst/och", 32'(och), 32'h0);
    irst = 1'b0;

    // Three words through channel 2
    step("w2", 1'b1, 2'd2, 8'h11, 1'b0, 2'd0, 1'b0);
    chk("w2/first_adr", 32'(owr_adr), 32'h20);
    step("w2", 1'b1, 2'd2, 8'h22, 1'b0, 2'd0, 1'b0);
    step("w2", 1'b1, 2'd2, 8'h33, 1'b0, 2'd0, 1'b0);
    chk("w2/last_adr", 32'(owr_adr), 32'h22);
    chk("w2/oempty", 32'(oempty), 32'hB);
    for (int i = 0; i < 3; i++) step("r2", 1'b0, 2'd0, '0, 1'b1, 2'd2, 1'b0);
    idle(6);

    // Fill channel 1, overflow, clear with coincident set, then plain clear
    for (int i = 0; i < DEP; i++) step("fill1", 1'b1, 2'd1, 8'(8'h40 + i), 1'b0, 2'd0, 1'b0);
    chk("fill1/ofull1", 32'(ofull[1]), 32'h1);
    step("ovf1", 1'b1, 2'd1, 8'hEE, 1'b0, 2'd0, 1'b0);
    chk("ovf1/oovf1", 32'(oovf[1]), 32'h1);
    step("clr_set", 1'b1, 2'd1, 8'hEF, 1'b0, 2'd0, 1'b1);
    chk("clr_set/oovf", 32'(oovf), 32'h2);
    step("clr", 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);
    chk("clr/oovf", 32'(oovf), 32'h0);

    // Underflow on empty channel 3
    step("udf3", 1'b0, 2'd0, '0, 1'b1, 2'd3, 1'b0);
    chk("udf3/oudf3", 32'(oudf[3]), 32'h1);
    step("clr", 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);

    // Fill channel 0, then write and read it in the same cycle
    for (int i = 0; i < DEP; i++) step("fill0", 1'b1, 2'd0, 8'(8'h80 + i), 1'b0, 2'd0, 1'b0);
    step("wr_rd_full", 1'b1, 2'd0, 8'hAA, 1'b1, 2'd0, 1'b0);
    chk("wr_rd_full/oovf0", 32'(oovf[0]), 32'h1);
    chk("wr_rd_full/ofull0", 32'(ofull[0]), 32'h0);
    step("clr", 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);

    // Streaming pairs on channel 0 walk the pointers across the wrap
    for (int i = 0; i < 40; i++)
      step("pair0", 1'b1, 2'd0, 8'($urandom_range(0, 255)), 1'b1, 2'd0, 1'b0);
    idle(6);

    // Clock-enable gaps during a read burst and while data is in flight
    for (int i = 0; i < 8; i++) begin
      iclk_ena = !(i == 3 || i == 4);
      step("ena_burst", 1'b0, 2'd0, '0, 1'b1, 2'd0, 1'b0);
    end
    iclk_ena = 1'b0;
    idle(2);
    iclk_ena = 1'b1;
    idle(8);
    chk("ena/sb_drained", 32'(sb.size()), 32'h0);

    // Reset in the middle of a read burst
    for (int i = 0; i < 4; i++) step("rst_burst", 1'b0, 2'd0, '0, 1'b1, 2'd1, 1'b0);
    irst = 1'b1;
    @(posedge iclk); #1;
    chk("midrst/oval", 32'(oval), 32'h0);
    chk("midrst/oempty", 32'(oempty), 32'hF);
    chk("midrst/ofull", 32'(ofull), 32'h0);
    chk("midrst/ordena", 32'(ordena), 32'h0);
    irst = 1'b0;
    model_reset();
    idle(6);
    step("post_rst_w", 1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 1'b0);
    chk("post_rst/owr_adr", 32'(owr_adr), 32'h20);
    step("post_rst_r", 1'b0, 2'd0, '0, 1'b1, 2'd2, 1'b0);
    idle(6);
    chk("end/sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
